switch_conditioner: RTL and testbench
=====================================

// Module: switch_conditioner
// PURPOSE
//  Front-end for one raw Go Board push-button. Synchronises, debounces and edge-detects the switch.
//  Emits single-cycle press/release pulses for the up/down digit counters that drive the 7-segment displays.
//  Sits between the board pin and the counter logic. One instance per switch.
// PARAMETERS
//  DEBOUNCE_LIMIT  250000  consecutive cycles a new level must persist before it is accepted (10 ms @ 25 MHz); >=1
//  REPEAT_DELAY    12500000 cycles from initial press pulse to first auto-repeat pulse (0.5 s); >=1
//  REPEAT_RATE     2500000 cycles between subsequent auto-repeat pulses (0.1 s); >=1
// PORTS
//  i_Clk      in   1  system clock, 25 MHz
//  i_Rst      in   1  reset: synchronous to i_Clk, active-high
//  i_Switch   in   1  raw, asynchronous, bouncing switch level (1 = pressed)
//  o_Switch   out  1  debounced level
//  o_Press    out  1  one-cycle pulse per accepted press (plus auto-repeats when enabled)
//  o_Release  out  1  one-cycle pulse per accepted release
// BEHAVIOUR
//  - Reset: sync1, sync2, stable, o_Switch, o_Press and o_Release all 0; debounce count 0; repeat FSM IDLE, timer 0.
//  - Synchroniser: sync1 <= i_Switch; sync2 <= sync1. No logic between the two flops.
//  - Debounce, width $clog2(DEBOUNCE_LIMIT+1):
//    - sync2==stable: count <= 0.
//    - Otherwise, count==DEBOUNCE_LIMIT-1: stable <= sync2 and count <= 0.
//    - Otherwise: count <= count+1.
//    - Any bounce back to stable restarts the count, so glitches shorter than DEBOUNCE_LIMIT never pass.
//  - Latency: if edge N first samples a new i_Switch level and it holds, o_Switch changes after edge N+DEBOUNCE_LIMIT+1.
//  - o_Switch = stable, registered.
//  - o_Press and o_Release are registered. They are high exactly in the first cycle o_Switch shows 1 (resp. 0) after a change. Never both high.
//  - Reset mid-bounce discards partial counts.
//  - Switch held through reset release is treated as a fresh press: o_Press fires DEBOUNCE_LIMIT+2 edges after reset deasserts.
//  - i_Rst has priority over every other event in the same cycle.
// CONFIGURATION
//  Macro SWITCH_CONDITIONER_AUTO_REPEAT_EN:
//  - Defined: repeat FSM and timer compiled in.
//    - States: IDLE -> DELAY on accepted press (timer <= 0). DELAY -> REPEAT when timer==REPEAT_DELAY-1 (o_Press pulses, timer <= 0).
//    - REPEAT pulses o_Press whenever timer==REPEAT_RATE-1, then timer <= 0.
//    - Accepted release from DELAY/REPEAT -> IDLE the same cycle; no pulse in that cycle.
//    - Timer width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1); never wraps.
//  - Undefined: no FSM or timer logic. REPEAT_* parameters are accepted but unused; o_Press fires once per press.
// STRUCTURE
//  - Shared package switch_cond_pkg: repeat-state encoding (IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2).
//  - Same package also holds board constants: CLK_HZ=25000000, DEFAULT_DEBOUNCE_LIMIT, DEFAULT_REPEAT_DELAY, DEFAULT_REPEAT_RATE.
//  - One sub-module, switch_debounce_core: synchroniser plus debounce counter, outputs stable level.
//  - Top level adds edge detect and the optional repeat FSM.
// TESTING (bench parameters DEBOUNCE_LIMIT=4, REPEAT_DELAY=10, REPEAT_RATE=3; edge 0 = first edge sampling change)
//  1. Reset hold with i_Switch=1 -> all outputs 0 throughout; after release, o_Switch=1 and o_Press=1 for one cycle after edge 5.
//  2. Clean press from idle -> o_Switch rises after edge 5; o_Press single pulse there; o_Release stays 0.
//  3. Bounce 1,0,1,1,0 then steady 1 -> no output change until 4 consecutive sync2 mismatches; one o_Press only.
//  4. 3-cycle glitch high while o_Switch=0 -> o_Switch, o_Press, o_Release remain 0.
//  5. Press held, then released after debounce -> o_Release one-cycle pulse after release edge+5; o_Switch falls same cycle.
//  6. With SWITCH_CONDITIONER_AUTO_REPEAT_EN, hold 30 cycles after press pulse at cycle T -> o_Press at T, T+10, T+13, T+16 ...
//     Release -> no further o_Press.

Source files
------------

// File: rtl/switch_cond_pkg.sv
// Board-level constants and the auto-repeat state encoding shared by the
// switch_conditioner slice.
package switch_cond_pkg;

    localparam int unsigned CLK_HZ                 = 25_000_000;
    localparam int unsigned DEFAULT_DEBOUNCE_LIMIT = CLK_HZ / 100;
    localparam int unsigned DEFAULT_REPEAT_DELAY   = CLK_HZ / 2;
    localparam int unsigned DEFAULT_REPEAT_RATE    = CLK_HZ / 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } repeat_state_e;

endpackage

// File: rtl/switch_debounce_core.sv
// Two-flop synchroniser followed by a persistence counter; exposes the accepted
// level and the level it will take on the next edge.
module switch_debounce_core
    import switch_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Stable,
    output logic o_Stable_Next
);

    localparam int unsigned        CNT_W    = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Count only while the synchronised level disagrees with the accepted one;
    // any agreement drops the count back to zero.
    always_comb begin
        sync1_d  = i_Switch;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        count_d  = '0;
        if (sync2_q != stable_q) begin
            if (count_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            count_q  <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            count_q  <= count_d;
        end
    end

    assign o_Stable      = stable_q;
    assign o_Stable_Next = stable_d;

endmodule

// File: rtl/switch_conditioner.sv
// Debounced push-button front end with press/release pulses. Defining
// SWITCH_CONDITIONER_AUTO_REPEAT_EN adds hold-to-repeat press pulses.
module switch_conditioner
    import switch_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int unsigned REPEAT_DELAY   = DEFAULT_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE    = DEFAULT_REPEAT_RATE
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Press,
    output logic o_Release
);

    logic stable;
    logic stable_next;
    logic press_d, press_q;
    logic release_d, release_q;

    if (DEBOUNCE_LIMIT == 0 || REPEAT_DELAY == 0 || REPEAT_RATE == 0) begin : g_bad_params
        $error("switch_conditioner: DEBOUNCE_LIMIT, REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    switch_debounce_core #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_core (
        .i_Clk        (i_Clk),
        .i_Rst        (i_Rst),
        .i_Switch     (i_Switch),
        .o_Stable     (stable),
        .o_Stable_Next(stable_next)
    );

`ifdef SWITCH_CONDITIONER_AUTO_REPEAT_EN
    localparam int unsigned TIMER_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] DELAY_LAST = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] RATE_LAST  = TIMER_W'(REPEAT_RATE - 1);

    repeat_state_e      state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    // An accepted release wins over a repeat tick due in the same cycle.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        press_d   = stable_next & ~stable;
        release_d = stable & ~stable_next;
        case (state_q)
            IDLE: begin
                if (press_d) begin
                    state_d = DELAY;
                    timer_d = '0;
                end
            end
            DELAY: begin
                if (release_d) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == DELAY_LAST) begin
                    state_d = REPEAT;
                    timer_d = '0;
                    press_d = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            REPEAT: begin
                if (release_d) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == RATE_LAST) begin
                    timer_d = '0;
                    press_d = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end
`else
    always_comb begin
        press_d   = stable_next & ~stable;
        release_d = stable & ~stable_next;
    end
`endif

    // Pulses are registered alongside the accepted level so they line up with o_Switch.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign o_Switch  = stable;
    assign o_Press   = press_q;
    assign o_Release = release_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Self-checking bench for switch_conditioner against a window-based reference model.
module tb_switch_conditioner;

    localparam int unsigned L = 4;
    localparam int unsigned D = 10;
    localparam int unsigned R = 3;

`ifdef SWITCH_CONDITIONER_AUTO_REPEAT_EN
    localparam bit AUTO_REPEAT = 1'b1;
`else
    localparam bit AUTO_REPEAT = 1'b0;
`endif

    logic i_Clk    = 1'b0;
    logic i_Rst    = 1'b1;
    logic i_Switch = 1'b0;
    logic o_Switch, o_Press, o_Release;

    int checks = 0;
    int errors = 0;

    // Reference model: a level is accepted once the last L synchronised samples all
    // show it; reset edges poison the window.
    bit eff_q[$];
    int seen_q[$];
    bit m_stable, m_press, m_release;
    int m_edge = 0;
    int m_press_edge = 0;

    switch_conditioner #(
        .DEBOUNCE_LIMIT(L),
        .REPEAT_DELAY  (D),
        .REPEAT_RATE   (R)
    ) dut (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Switch (i_Switch),
        .o_Switch (o_Switch),
        .o_Press  (o_Press),
        .o_Release(o_Release)
    );

    always #5 i_Clk = ~i_Clk;

    function automatic void model_edge(bit rst, bit sw);
        bit flip;
        bit want;
        int since;
        m_edge++;
        m_press   = 1'b0;
        m_release = 1'b0;
        if (rst) begin
            seen_q.push_back(2);
            eff_q.push_back(1'b0);
            m_stable = 1'b0;
        end else begin
            seen_q.push_back(int'(eff_q[eff_q.size() - 2]));
            want = !m_stable;
            flip = 1'b1;
            for (int i = 0; i < int'(L); i++)
                if (seen_q[seen_q.size() - 1 - i] != int'(want)) flip = 1'b0;
            since = m_edge - m_press_edge;
            if (flip) begin
                m_stable  = want;
                m_press   = want;
                m_release = !want;
                if (want) m_press_edge = m_edge;
            end else if (AUTO_REPEAT && m_stable && since >= int'(D) &&
                         ((since - int'(D)) % int'(R)) == 0) begin
                m_press = 1'b1;
            end
            eff_q.push_back(sw);
        end
        while (eff_q.size() > 8) void'(eff_q.pop_front());
        while (seen_q.size() > 8) void'(seen_q.pop_front());
    endfunction

    task automatic tick(input bit rst, input bit sw);
        i_Rst    = rst;
        i_Switch = sw;
        @(posedge i_Clk);
        model_edge(rst, sw);
        #1;
    endtask

    task automatic test_reset();
        int press_k = -1;
        for (int k = 0; k < 6; k++) begin
            tick(1'b1, 1'b1);
            checks++;
            if ({o_Switch, o_Press, o_Release} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL reset_hold k=%0d got=%b want=000", k, {o_Switch, o_Press, o_Release});
            end
        end
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 1'b1);
            if (o_Press === 1'b1 && press_k < 0) press_k = k;
            checks++;
            if ({o_Switch, o_Press, o_Release} !== {m_stable, m_press, m_release}) begin
                errors++;
                $display("[TB] FAIL reset_release k=%0d got=%b want=%b", k,
                         {o_Switch, o_Press, o_Release}, {m_stable, m_press, m_release});
            end
        end
        checks++;
        if (press_k !== 5) begin
            errors++;
            $display("[TB] FAIL reset_press_edge got=%0d want=5", press_k);
        end
    endtask

    task automatic test_release();
        int rel_k = -1;
        int low_k = -1;
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 1'b0);
            if (o_Release === 1'b1 && rel_k < 0) rel_k = k;
            if (o_Switch === 1'b0 && low_k < 0) low_k = k;
            checks++;
            if ({o_Switch, o_Press, o_Release} !== {m_stable, m_press, m_release}) begin
                errors++;
                $display("[TB] FAIL release k=%0d got=%b want=%b", k,
                         {o_Switch, o_Press, o_Release}, {m_stable, m_press, m_release});
            end
        end
        checks++;
        if (rel_k !== 5 || low_k !== 5) begin
            errors++;
            $display("[TB] FAIL release_edge got rel=%0d low=%0d want 5/5", rel_k, low_k);
        end
    endtask

    task automatic test_press_clean();
        int press_k = -1;
        int rel_n = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 1'b1);
            if (o_Press === 1'b1 && press_k < 0) press_k = k;
            if (o_Release === 1'b1) rel_n++;
            checks++;
            if ({o_Switch, o_Press, o_Release} !== {m_stable, m_press, m_release}) begin
                errors++;
                $display("[TB] FAIL press_clean k=%0d got=%b want=%b", k,
                         {o_Switch, o_Press, o_Release}, {m_stable, m_press, m_release});
            end
        end
        checks++;
        if (press_k !== 5 || rel_n !== 0) begin
            errors++;
            $display("[TB] FAIL press_clean_edge got press=%0d rel=%0d want 5/0", press_k, rel_n);
        end
    endtask

    task automatic test_bounce();
        logic [22:0] pat = 23'b00000000_11111111_01101;
        int press_n = 0;
        int rel_n = 0;
        int press_k = -1;
        for (int k = 0; k < 23; k++) begin
            tick(1'b0, pat[k]);
            if (o_Press === 1'b1) begin
                press_n++;
                if (press_k < 0) press_k = k;
            end
            if (o_Release === 1'b1) rel_n++;
            checks++;
            if ({o_Switch, o_Press, o_Release} !== {m_stable, m_press, m_release}) begin
                errors++;
                $display("[TB] FAIL bounce k=%0d got=%b want=%b", k,
                         {o_Switch, o_Press, o_Release}, {m_stable, m_press, m_release});
            end
        end
        checks++;
        if (press_n !== 1 || press_k !== 10 || rel_n !== 1) begin
            errors++;
            $display("[TB] FAIL bounce_count got press=%0d@%0d rel=%0d want 1@10 rel 1",
                     press_n, press_k, rel_n);
        end
    endtask

    task automatic test_glitch();
        for (int k = 0; k < 11; k++) begin
            tick(1'b0, k < 3);
            checks++;
            if ({o_Switch, o_Press, o_Release} !== 3'b000 ||
                {m_stable, m_press, m_release} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL glitch k=%0d got=%b want=000", k, {o_Switch, o_Press, o_Release});
            end
        end
    endtask

    task automatic test_auto_repeat();
        int press_n = 0;
        int late_n = 0;
        int rel_n = 0;
        for (int k = 0; k < 48; k++) begin
            tick(1'b0, k < 36);
            if (k < 36 && o_Press === 1'b1) press_n++;
            if (rel_n > 0 && o_Press === 1'b1) late_n++;
            if (o_Release === 1'b1) rel_n++;
            checks++;
            if ({o_Switch, o_Press, o_Release} !== {m_stable, m_press, m_release}) begin
                errors++;
                $display("[TB] FAIL auto_repeat k=%0d got=%b want=%b", k,
                         {o_Switch, o_Press, o_Release}, {m_stable, m_press, m_release});
            end
        end
        checks++;
        if (press_n !== (AUTO_REPEAT ? 8 : 1) || late_n !== 0 || rel_n !== 1) begin
            errors++;
            $display("[TB] FAIL auto_repeat_count got press=%0d late=%0d rel=%0d want %0d/0/1",
                     press_n, late_n, rel_n, AUTO_REPEAT ? 8 : 1);
        end
    endtask

    task automatic test_reset_mid_bounce();
        int press_k = -1;
        for (int k = 0; k < 22; k++) begin
            tick(k == 3, k < 14);
            if (o_Press === 1'b1 && press_k < 0) press_k = k;
            checks++;
            if ({o_Switch, o_Press, o_Release} !== {m_stable, m_press, m_release}) begin
                errors++;
                $display("[TB] FAIL reset_mid_bounce k=%0d got=%b want=%b", k,
                         {o_Switch, o_Press, o_Release}, {m_stable, m_press, m_release});
            end
        end
        checks++;
        if (press_k !== 9) begin
            errors++;
            $display("[TB] FAIL reset_mid_bounce_edge got=%0d want=9", press_k);
        end
    endtask

    task automatic test_random();
        bit lvl = 1'b0;
        int run = 0;
        bit rst;
        for (int k = 0; k < 600; k++) begin
            if (run == 0) begin
                lvl = 1'($urandom_range(0, 1));
                run = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 40)) : int'($urandom_range(1, 6));
            end
            run--;
            rst = ($urandom_range(0, 99) == 0);
            tick(rst, lvl);
            checks++;
            if ({o_Switch, o_Press, o_Release} !== {m_stable, m_press, m_release} ||
                (o_Press === 1'b1 && o_Release === 1'b1)) begin
                errors++;
                $display("[TB] FAIL random k=%0d rst=%0b got=%b want=%b", k, rst,
                         {o_Switch, o_Press, o_Release}, {m_stable, m_press, m_release});
            end
        end
    endtask

    initial begin
        eff_q  = '{1'b0, 1'b0};
        seen_q = '{2, 2, 2, 2};
        m_stable  = 1'b0;
        m_press   = 1'b0;
        m_release = 1'b0;
        #2;
        test_reset();
        test_release();
        test_press_clean();
        test_release();
        test_bounce();
        test_glitch();
        test_auto_repeat();
        test_reset_mid_bounce();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
